// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: an input side (instruction, format
// select, tag) and an output side (extended immediate, tag, error flag).
// slave is the block's view; master is the producer/consumer view.
// XLEN and TAG_W must match the parameters of the attached imm_extend_pipe.
`timescale 1ns/1ps
interface imm_extend_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [2:0]       immsrc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  immext;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, instr, immsrc, in_tag, out_ready,
        input  in_ready, out_valid, immext, out_tag, out_err
    );

    modport slave (
        input  in_valid, instr, immsrc, in_tag, out_ready,
        output in_ready, out_valid, immext, out_tag, out_err
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: RISC-V immediate decoder behind a two-entry in-order
// buffer. The immediate is decoded when an instruction is accepted and
// stored; the output side only ever sees stored values.
// Optional feature: define IMM_EXTEND_PIPE_ERR_EN to store and report an
// out_err flag for the illegal format select (3'b111). Without it out_err
// is a constant 0 and no flag storage exists.
`timescale 1ns/1ps
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    imm_extend_pipe_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } cnt_e;

    // Widen a 32-bit signed value to XLEN, replicating bit 31.
    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    // Build the extended immediate for one instruction word and format.
    function automatic logic [XLEN-1:0] imm_decode(input logic [31:0] ins,
                                                   input logic [2:0]  src);
        logic signed [31:0] s;
        logic [XLEN-1:0]    r;
        s = '0;
        r = '0;
        case (src)
            3'b000: begin
                s = {{20{ins[31]}}, ins[31:20]};
                r = sext32(s);
            end
            3'b001: begin
                s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                r = sext32(s);
            end
            3'b010: begin
                s = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                r = sext32(s);
            end
            3'b011: begin
                s = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                r = sext32(s);
            end
            3'b100: begin
                s = {ins[31:12], 12'b0};
                r = sext32(s);
            end
            3'b101:  r = XLEN'(ins[19:15]);
            3'b110:  r = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
            default: r = '0;
        endcase
        return r;
    endfunction

    cnt_e             cnt_p1;
    cnt_e             cnt_nxt;
    logic             wr_ptr_p1;
    logic             rd_ptr_p1;
    logic             vld_p1;
    logic             rdy_p1;
    logic             push;
    logic             pop;

    logic [XLEN-1:0]  imm_p0;
    logic [XLEN-1:0]  mem_imm_p1 [2];
    logic [TAG_W-1:0] mem_tag_p1 [2];

    // Opcode bits play no part in any immediate format.
    logic             unused_opcode;
    assign unused_opcode = ^bus.instr[6:0];

    // ---- p0: decode at the input transfer ----
    assign push   = bus.in_valid && rdy_p1;
    assign pop    = vld_p1 && bus.out_ready;
    assign imm_p0 = imm_decode(bus.instr, bus.immsrc);

    // Next occupancy from the push/pop pair; FULL never sees a push since
    // in_ready is low there.
    always_comb begin
        cnt_nxt = cnt_p1;
        case (cnt_p1)
            EMPTY:   if (push) cnt_nxt = ONE;
            ONE: begin
                if (push && !pop)      cnt_nxt = FULL;
                else if (!push && pop) cnt_nxt = EMPTY;
            end
            FULL:    if (pop) cnt_nxt = ONE;
            default: cnt_nxt = EMPTY;
        endcase
    end

    // Occupancy state, pointers and registered handshake flags. in_ready
    // stays low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_p1    <= EMPTY;
            wr_ptr_p1 <= 1'b0;
            rd_ptr_p1 <= 1'b0;
            vld_p1    <= 1'b0;
            rdy_p1    <= 1'b0;
        end else begin
            cnt_p1 <= cnt_nxt;
            vld_p1 <= (cnt_nxt != EMPTY);
            rdy_p1 <= (cnt_nxt != FULL);
            if (push) wr_ptr_p1 <= ~wr_ptr_p1;
            if (pop)  rd_ptr_p1 <= ~rd_ptr_p1;
        end
    end

    // ---- p1: two-entry storage, written on push ----
    // Data storage carries no reset; the output is gated by vld_p1 instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_imm_p1[wr_ptr_p1] <= imm_p0;
            mem_tag_p1[wr_ptr_p1] <= bus.in_tag;
        end
    end

`ifdef IMM_EXTEND_PIPE_ERR_EN
    logic err_p0;
    logic mem_err_p1 [2];

    assign err_p0 = (bus.immsrc == 3'b111);

    // Illegal-format flag stored alongside its immediate.
    always_ff @(posedge clk) begin
        if (push) mem_err_p1[wr_ptr_p1] <= err_p0;
    end

    assign bus.out_err = vld_p1 & mem_err_p1[rd_ptr_p1];
`else
    assign bus.out_err = 1'b0;
`endif

    // ---- output: head entry, forced to zero while nothing is held ----
    assign bus.in_ready  = rdy_p1;
    assign bus.out_valid = vld_p1;
    assign bus.immext    = vld_p1 ? mem_imm_p1[rd_ptr_p1] : '0;
    assign bus.out_tag   = vld_p1 ? mem_tag_p1[rd_ptr_p1] : '0;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: a 32-bit and a 64-bit instance.
// Drivers push hand-computed expectations into per-instance queues;
// monitors pop and compare on every output transfer.
`timescale 1ns/1ps
module tb_imm_extend_pipe;
    localparam int TAG_W = 4;
`ifdef IMM_EXTEND_PIPE_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imm_extend_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) bus32();
    imm_extend_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) bus64();

    imm_extend_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .reset_n(reset_n), .bus(bus32)
    );
    imm_extend_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .reset_n(reset_n), .bus(bus64)
    );

    typedef struct {
        logic [63:0]      imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && bus32.out_valid && bus32.out_ready) begin
            if (q32.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out32_unexpected: got tag %0d, expected no output", bus32.out_tag);
            end else begin
                e = q32.pop_front();
                check("imm32", 64'(bus32.immext), e.imm);
                check("tag32", 64'(bus32.out_tag), 64'(e.tag));
                check("err32", 64'(bus32.out_err), 64'(e.err));
            end
        end
    end

    // Monitor for the 64-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && bus64.out_valid && bus64.out_ready) begin
            if (q64.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out64_unexpected: got tag %0d, expected no output", bus64.out_tag);
            end else begin
                e = q64.pop_front();
                check("imm64", bus64.immext, e.imm);
                check("tag64", 64'(bus64.out_tag), 64'(e.tag));
                check("err64", 64'(bus64.out_err), 64'(e.err));
            end
        end
    end

    task automatic put32(input logic [31:0] ins, input logic [2:0] src,
                         input logic [TAG_W-1:0] tag, input logic [63:0] imm, input logic err);
        exp_t e;
        int   waits;
        bus32.in_valid = 1'b1;
        bus32.instr    = ins;
        bus32.immsrc   = src;
        bus32.in_tag   = tag;
        waits = 0;
        @(negedge clk);
        while (!bus32.in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!bus32.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept32: in_ready=0 after 20 cycles, required 1 (tag %0d)", tag);
        end else begin
            e.imm = imm; e.tag = tag; e.err = err;
            q32.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic put64(input logic [31:0] ins, input logic [2:0] src,
                         input logic [TAG_W-1:0] tag, input logic [63:0] imm, input logic err);
        exp_t e;
        int   waits;
        bus64.in_valid = 1'b1;
        bus64.instr    = ins;
        bus64.immsrc   = src;
        bus64.in_tag   = tag;
        waits = 0;
        @(negedge clk);
        while (!bus64.in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!bus64.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept64: in_ready=0 after 20 cycles, required 1 (tag %0d)", tag);
        end else begin
            e.imm = imm; e.tag = tag; e.err = err;
            q64.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    // Burst table for the 32-bit instance: instr, immsrc, expected immediate.
    logic [31:0] v_ins [10] = '{32'h02602e23, 32'h000003b7, 32'hfff00093, 32'hfe000ee3,
                                32'h0080006f, 32'hffffffff, 32'hffffffff, 32'hffffffff,
                                32'h800000b7, 32'hfe000fa3};
    logic [2:0]  v_src [10] = '{3'b001, 3'b100, 3'b000, 3'b010, 3'b011,
                                3'b101, 3'b110, 3'b111, 3'b100, 3'b001};
    logic [63:0] v_imm [10] = '{64'h3C, 64'h0, 64'hFFFFFFFF, 64'hFFFFFFFC, 64'h8,
                                64'h1F, 64'h1F, 64'h0, 64'h80000000, 64'hFFFFFFFF};

    initial begin
        int t0;
        int w;
        bus32.in_valid = 1'b0; bus32.instr = '0; bus32.immsrc = '0; bus32.in_tag = '0;
        bus32.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.instr = '0; bus64.immsrc = '0; bus64.in_tag = '0;
        bus64.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus32.out_valid), 64'h0);
        check("rst_in_ready",  64'(bus32.in_ready),  64'h0);
        check("rst_immext",    64'(bus32.immext),    64'h0);
        check("rst_out_tag",   64'(bus32.out_tag),   64'h0);
        check("rst_out_err",   64'(bus32.out_err),   64'h0);
        check("rst_out_valid64", 64'(bus64.out_valid), 64'h0);

        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_rst", 64'(bus32.in_ready), 64'h1);

        // Single instruction: visible the cycle after acceptance.
        put32(32'h00134313, 3'b000, 4'd1, 64'h1, 1'b0);
        bus32.in_valid = 1'b0;
        check("latency_out_valid", 64'(bus32.out_valid), 64'h1);
        check("latency_immext",    64'(bus32.immext),    64'h1);

        // Back-to-back burst covering every format.
        t0 = cyc;
        for (int i = 0; i < 10; i++)
            put32(v_ins[i], v_src[i], TAG_W'(i + 2), v_imm[i], (v_src[i] == 3'b111) ? ERR_ON : 1'b0);
        bus32.in_valid = 1'b0;
        check("burst_cycles", 64'(cyc - t0), 64'd10);

        // 64-bit formats.
        put64(32'h800000b7, 3'b100, 4'd1, 64'hFFFFFFFF80000000, 1'b0);
        put64(32'h03f01013, 3'b110, 4'd2, 64'h3F, 1'b0);
        put64(32'hfff00093, 3'b000, 4'd3, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        put64(32'hfe000ee3, 3'b010, 4'd4, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        put64(32'hffffffff, 3'b101, 4'd5, 64'h1F, 1'b0);
        put64(32'hffffffff, 3'b111, 4'd6, 64'h0, ERR_ON);
        bus64.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: fill, refuse a third, then drain in order.
        bus32.out_ready = 1'b0;
        put32(32'h00134313, 3'b000, 4'd1, 64'h1, 1'b0);
        put32(32'h02602e23, 3'b001, 4'd2, 64'h3C, 1'b0);
        bus32.in_valid = 1'b0;
        check("in_ready_full", 64'(bus32.in_ready), 64'h0);
        bus32.in_valid = 1'b1; bus32.instr = 32'hffffffff; bus32.immsrc = 3'b000; bus32.in_tag = 4'd3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(bus32.in_ready), 64'h0);
            check("stall_tag",      64'(bus32.out_tag),  64'h1);
            check("stall_immext",   64'(bus32.immext),   64'h1);
        end
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        bus32.out_ready = 1'b1;
        @(negedge clk);
        check("pop_cycle_in_ready", 64'(bus32.in_ready), 64'h0);
        @(negedge clk);
        check("after_pop_in_ready", 64'(bus32.in_ready), 64'h1);
        check("second_tag",         64'(bus32.out_tag),  64'h2);
        @(posedge clk); #1;

        // Reset with the buffer full discards both entries.
        bus32.out_ready = 1'b0;
        bus32.in_valid = 1'b1; bus32.instr = 32'h00134313; bus32.immsrc = 3'b000; bus32.in_tag = 4'd7;
        @(posedge clk); #1;
        bus32.in_tag = 4'd8;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        check("full_before_rst", 64'({bus32.out_valid, bus32.in_ready}), 64'h2);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus32.out_valid), 64'h0);
        check("midrst_in_ready",  64'(bus32.in_ready),  64'h0);
        check("midrst_immext",    64'(bus32.immext),    64'h0);
        check("midrst_out_tag",   64'(bus32.out_tag),   64'h0);
        @(negedge clk) reset_n = 1'b1;
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        put32(32'h0080006f, 3'b011, 4'd5, 64'h8, 1'b0);
        bus32.in_valid = 1'b0;

        w = 0;
        while ((q32.size() != 0 || q64.size() != 0) && w < 50) begin
            @(posedge clk);
            w++;
        end
        n_tests++;
        if (q32.size() != 0 || q64.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d entries outstanding, required 0/0", q32.size(), q64.size());
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried with each instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  instr/immsrc/in_tag valid this cycle.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 instr  input  32  instruction word; bits [6:0] ignored.
REQ-008 immsrc  input  3  immediate format select.
REQ-009 in_tag  input  TAG_W  sideband tag, passed through unchanged.
REQ-010 out_valid  output  1  immext/out_tag/out_err valid.
REQ-011 out_ready  input  1  downstream accepts output this cycle.
REQ-012 immext  output  XLEN  sign/zero-extended immediate.
REQ-013 out_tag  output  TAG_W  tag of the instruction at the output.
REQ-014 out_err  output  1  illegal immsrc flag (see Configuration).

Function
REQ-015 Format map: 000 I {sext instr[31:20]}; 001 S {sext instr[31:25],instr[11:7]}; 010 B {sext instr[31],instr[7],instr[30:25],instr[11:8],0}; 011 J {sext instr[31],instr[19:12],instr[20],instr[30:21],0}; 100 U {sext instr[31:12],12'b0}.
REQ-016 101 Z (CSR zimm): instr[19:15] zero-extended to XLEN.
REQ-017 110 SHAMT: instr[24:20] zero-extended when XLEN=32; instr[25:20] zero-extended when XLEN=64.
REQ-018 111 illegal: immext = 0.
REQ-019 Sign extension replicates instr[31] up to bit XLEN-1 for all signed formats, including U when XLEN=64.
REQ-020 Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-021 Decode is computed at input transfer and stored; outputs come from storage only, no combinational path from instr to immext.
REQ-022 Two-entry in-order buffer, count states EMPTY(0), ONE(1), FULL(2).
REQ-023 Transitions: EMPTY push->ONE; ONE push only->FULL; ONE pop only->EMPTY; ONE push+pop->ONE; FULL pop->ONE; no event->hold.
REQ-024 in_ready = (count != FULL), derived from registered count only.
REQ-025 out_valid = (count != EMPTY); head entry drives immext/out_tag/out_err.
REQ-026 Latency: accepted instruction appears at output in the next cycle when buffer empty; sustained throughput 1 per cycle with out_ready held high.
REQ-027 Output stable: while out_valid && !out_ready, immext/out_tag/out_err hold unchanged.
REQ-028 Ordering: outputs delivered in exactly input-acceptance order; no drop, no duplicate.
REQ-029 FULL with out_ready=1: pop occurs, in_ready stays 0 that cycle, becomes 1 next cycle.
REQ-030 Storage pointers wrap modulo 2.

Reset
REQ-031 While reset_n=0: count=EMPTY, out_valid=0, in_ready=0, immext=0, out_tag=0, out_err=0, pointers=0.
REQ-032 in_ready rises in the first cycle after reset_n deassert.
REQ-033 Reset mid-operation discards all buffered entries immediately; no partial output.

Configuration
REQ-034 Macro IMM_EXTEND_PIPE_ERR_EN.
REQ-035 Defined: immsrc=111 stores out_err=1 with immext=0; other formats out_err=0.
REQ-036 Undefined: out_err tied 0 constantly, no storage for it; immsrc=111 still yields immext=0.

Verification
REQ-037 XLEN=32, instr=32'h00134313, immsrc=000, out_ready=1 -> next cycle out_valid=1, immext=32'h00000001.
REQ-038 XLEN=32, instr=32'h02602e23, immsrc=001 -> immext=32'h0000003C; instr=32'h000003b7, immsrc=100 -> immext=32'h00000000.
REQ-039 XLEN=64, instr=32'h800000b7, immsrc=100 -> immext=64'hFFFFFFFF80000000; instr=32'h03f01013, immsrc=110 -> immext=64'h3F.
REQ-040 out_ready=0, push tags 1,2 -> in_ready=0 after second; third in_valid ignored; raise out_ready -> tags 1 then 2 in consecutive cycles, in_ready=1 one cycle after first pop.
REQ-041 ERR_EN defined, immsrc=111 -> out_err=1, immext=0; undefined -> out_err=0.
REQ-042 Assert reset_n=0 with buffer FULL -> out_valid=0 same cycle; after release first new input emerges with its own tag.
